// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: FSM states,
// opcode constants, ALU operation classes and datapath mux encodings.
// Used by multicycle_ctrl, the datapath and the ALU control decoder.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_LOAD  = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JAL    = 2'b10;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    // Only BEQ and BNE are resolved; every other branch flavour falls through.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_timeout.sv
// Memory-request timeout counter for multicycle_ctrl. Present only when
// MULTICYCLE_CTRL_TIMEOUT_EN is defined; the default build has no counter.
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
module mem_timeout_ctr #(
    parameter int unsigned TO_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [TO_W-1:0] count
);

    logic [TO_W-1:0] count_r;

    // Count stalled request cycles; cleared whenever the FSM changes state or aborts.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {TO_W{1'b0}};
        end else if (clr) begin
            count_r <= {TO_W{1'b0}};
        end else if (inc) begin
            count_r <= count_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule
`endif

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core. Outputs are decoded
// combinationally from the current state and inputs; reset forces them all low.
// Optional request timeout: define MULTICYCLE_CTRL_TIMEOUT_EN.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       alu_src_b,
    output logic [1:0] Alu_op,
    output logic       f7_zero,
    output logic       illegal,
    output logic       busy
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT - 1);

    state_t state_r;
    state_t next_state_s;
    logic   wait_s;
    logic   timeout_hit_s;

    // Flag cycles where a request is up but its matching ready is not.
    always_comb begin
        wait_s = 1'b0;
        case (state_r)
            S_FETCH:  wait_s = ~imem_ready;
            S_MEM_RD: wait_s = ~dmem_ready;
            S_MEM_WR: wait_s = ~dmem_ready;
            default:  wait_s = 1'b0;
        endcase
    end

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    logic [TO_W-1:0] to_count_s;
    logic            to_clr_s;

    // An abort from FETCH loops back to FETCH, so the abort itself also clears.
    assign to_clr_s      = (next_state_s != state_r) | timeout_hit_s;
    assign timeout_hit_s = wait_s & (to_count_s == TO_LIMIT);

    mem_timeout_ctr #(.TO_W(TO_W)) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr   (to_clr_s),
        .inc   (wait_s),
        .count (to_count_s)
    );
`else
    logic [TO_W:0] unused_to_s;
    assign unused_to_s   = {wait_s, TO_LIMIT};
    assign timeout_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and output decode; reset overrides everything.
    always_comb begin
        next_state_s = state_r;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_PLUS4;
        reg_we       = 1'b0;
        wb_sel       = WB_SEL_ALU;
        alu_src_b    = 1'b0;
        Alu_op       = ALUOP_ADD;
        f7_zero      = 1'b0;
        illegal      = 1'b0;
        busy         = 1'b0;
        if (rst) begin
            next_state_s = S_FETCH;
        end else begin
            busy = (state_r != S_FETCH);
            case (state_r)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we        = 1'b1;
                        pc_we        = 1'b1;
                        next_state_s = S_DECODE;
                    end else if (timeout_hit_s) begin
                        illegal      = 1'b1;
                        next_state_s = S_FETCH;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_R:      next_state_s = S_EXEC_R;
                        OP_I:      next_state_s = S_EXEC_I;
                        OP_LOAD:   next_state_s = S_MEM_ADDR;
                        OP_STORE:  next_state_s = S_MEM_ADDR;
                        OP_BRANCH: next_state_s = S_BRANCH;
                        OP_JAL:    next_state_s = S_JAL;
                        default:   next_state_s = S_TRAP;
                    endcase
                end
                S_EXEC_R: begin
                    Alu_op       = ALUOP_FUNCT;
                    next_state_s = S_WB_ALU;
                end
                S_EXEC_I: begin
                    Alu_op       = ALUOP_FUNCT;
                    alu_src_b    = 1'b1;
                    f7_zero      = 1'b1;
                    next_state_s = S_WB_ALU;
                end
                S_WB_ALU: begin
                    // IR is stable, so the opcode tells which EXEC state preceded us.
                    Alu_op       = ALUOP_FUNCT;
                    alu_src_b    = (opcode == OP_I);
                    f7_zero      = (opcode == OP_I);
                    reg_we       = 1'b1;
                    wb_sel       = WB_SEL_ALU;
                    next_state_s = S_FETCH;
                end
                S_MEM_ADDR: begin
                    Alu_op    = ALUOP_ADD;
                    alu_src_b = 1'b1;
                    if (opcode == OP_LOAD) begin
                        next_state_s = S_MEM_RD;
                    end else begin
                        next_state_s = S_MEM_WR;
                    end
                end
                S_MEM_RD: begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        next_state_s = S_WB_LOAD;
                    end else if (timeout_hit_s) begin
                        illegal      = 1'b1;
                        next_state_s = S_FETCH;
                    end else begin
                        next_state_s = S_MEM_RD;
                    end
                end
                S_WB_LOAD: begin
                    reg_we       = 1'b1;
                    wb_sel       = WB_SEL_LOAD;
                    next_state_s = S_FETCH;
                end
                S_MEM_WR: begin
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                    if (dmem_ready) begin
                        next_state_s = S_FETCH;
                    end else if (timeout_hit_s) begin
                        illegal      = 1'b1;
                        next_state_s = S_FETCH;
                    end else begin
                        next_state_s = S_MEM_WR;
                    end
                end
                S_BRANCH: begin
                    Alu_op = ALUOP_SUB;
                    if (branch_taken(funct3, zero)) begin
                        pc_we  = 1'b1;
                        pc_src = PC_SRC_BRANCH;
                    end else begin
                        pc_we  = 1'b0;
                        pc_src = PC_SRC_PLUS4;
                    end
                    next_state_s = S_FETCH;
                end
                S_JAL: begin
                    reg_we       = 1'b1;
                    wb_sel       = WB_SEL_PC4;
                    pc_we        = 1'b1;
                    pc_src       = PC_SRC_JAL;
                    next_state_s = S_FETCH;
                end
                S_TRAP: begin
                    illegal      = 1'b1;
                    next_state_s = S_FETCH;
                end
                default: begin
                    next_state_s = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. Inputs change 1 time unit
// after each rising edge; outputs are sampled 1 time unit later.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       alu_src_b;
    logic [1:0] Alu_op;
    logic       f7_zero;
    logic       illegal;
    logic       busy;

    int checks_cnt;
    int fail_cnt;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .alu_src_b  (alu_src_b),
        .Alu_op     (Alu_op),
        .f7_zero    (f7_zero),
        .illegal    (illegal),
        .busy       (busy)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] all_outs();
        return {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we,
                wb_sel, alu_src_b, Alu_op, f7_zero, illegal, busy};
    endfunction

    // Zero-wait fetch then DECODE; leaves the bench in the cycle after DECODE.
    task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3);
        imem_ready = 1'b1;
        opcode     = op;
        funct3     = f3;
        #1;
        check("fetch_ir_we", ir_we, 1'b1);
        check("fetch_pc_we", pc_we, 1'b1);
        check("fetch_busy", busy, 1'b0);
        next_cycle();
        imem_ready = 1'b0;
        #1;
        check("decode_enables", {ir_we, pc_we, reg_we, dmem_req, imem_req}, 5'b00000);
        check("decode_busy", busy, 1'b1);
        next_cycle();
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst        = 1'b1;
        opcode     = 7'b0000000;
        funct3     = 3'b000;
        zero       = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;

        // Reset: all outputs low, two cycles.
        next_cycle();
        #1;
        check("reset_outs", all_outs(), 16'h0000);
        next_cycle();
        imem_ready = 1'b1;
        #1;
        check("reset_outs_ready", all_outs(), 16'h0000);
        rst        = 1'b0;
        imem_ready = 1'b0;

        // R-type add, zero-wait: 4 cycles.
        fetch_decode(7'b0110011, 3'b000);
        #1;
        check("r_exec_aluop", Alu_op, 2'b10);
        check("r_exec_srcb", alu_src_b, 1'b0);
        next_cycle();
        #1;
        check("r_wb_reg_we", reg_we, 1'b1);
        check("r_wb_sel", wb_sel, 2'b00);
        next_cycle();
        #1;
        check("r_back_fetch", {imem_req, busy, reg_we}, 3'b100);

        // ADDI, imem_ready delayed 3 cycles.
        opcode = 7'b0010011;
        for (int i = 0; i < 3; i++) begin
            check("addi_wait_req", imem_req, 1'b1);
            check("addi_wait_ir_we", ir_we, 1'b0);
            next_cycle();
            #1;
        end
        fetch_decode(7'b0010011, 3'b000);
        #1;
        check("addi_exec", {Alu_op, f7_zero, alu_src_b}, 4'b1011);
        next_cycle();
        #1;
        check("addi_wb", {reg_we, wb_sel, alu_src_b}, 4'b1001);
        next_cycle();

        // Load, dmem_ready after 2 wait cycles; stray imem_ready ignored.
        fetch_decode(7'b0000011, 3'b010);
        #1;
        check("ld_addr", {Alu_op, alu_src_b}, 3'b001);
        next_cycle();
        imem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("ld_wait_req", {dmem_req, dmem_we, ir_we}, 3'b100);
            next_cycle();
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b1;
        #1;
        check("ld_done_req", dmem_req, 1'b1);
        next_cycle();
        dmem_ready = 1'b0;
        #1;
        check("ld_wb", {reg_we, wb_sel, dmem_req}, 4'b1010);
        next_cycle();

        // Store, zero-wait.
        fetch_decode(7'b0100011, 3'b010);
        #1;
        check("st_addr_reg_we", reg_we, 1'b0);
        next_cycle();
        dmem_ready = 1'b1;
        #1;
        check("st_wr", {dmem_req, dmem_we, reg_we}, 3'b110);
        next_cycle();
        dmem_ready = 1'b0;
        #1;
        check("st_back_fetch", {busy, imem_req, reg_we}, 3'b010);

        // BEQ taken.
        fetch_decode(7'b1100011, 3'b000);
        zero = 1'b1;
        #1;
        check("beq_taken", {Alu_op, pc_we, pc_src}, 5'b01101);
        next_cycle();
        // BEQ not taken.
        fetch_decode(7'b1100011, 3'b000);
        zero = 1'b0;
        #1;
        check("beq_not_taken", pc_we, 1'b0);
        next_cycle();
        // BNE taken.
        fetch_decode(7'b1100011, 3'b001);
        #1;
        check("bne_taken", {pc_we, pc_src}, 3'b101);
        next_cycle();
        // BLT is not resolved here: never taken.
        fetch_decode(7'b1100011, 3'b100);
        zero = 1'b1;
        #1;
        check("blt_not_taken", pc_we, 1'b0);
        next_cycle();
        zero = 1'b0;

        // JAL.
        fetch_decode(7'b1101111, 3'b000);
        #1;
        check("jal", {reg_we, wb_sel, pc_we, pc_src}, 6'b110110);
        next_cycle();

        // Unsupported opcode -> one-cycle illegal.
        fetch_decode(7'b1110011, 3'b000);
        #1;
        check("trap_illegal", {illegal, reg_we, pc_we}, 3'b100);
        next_cycle();
        #1;
        check("trap_after", {illegal, busy, imem_req}, 3'b001);

        // Reset in the middle of MEM_RD.
        fetch_decode(7'b0000011, 3'b010);
        next_cycle();
        #1;
        check("rst_mid_req", dmem_req, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_outs", all_outs(), 16'h0000);
        next_cycle();
        rst = 1'b0;
        #1;
        check("rst_mid_after", {dmem_req, reg_we, imem_req, busy}, 4'b0010);

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
        // Stuck dmem_ready: abort on the 16th request cycle.
        fetch_decode(7'b0000011, 3'b010);
        next_cycle();
        for (int i = 0; i < 16; i++) begin
            #1;
            check("to_req", dmem_req, 1'b1);
            check("to_illegal", illegal, (i == 15) ? 1'b1 : 1'b0);
            check("to_reg_we", reg_we, 1'b0);
            next_cycle();
        end
        #1;
        check("to_after", {busy, imem_req, illegal}, 3'b010);
`else
        // Without the timeout a stalled load waits indefinitely.
        fetch_decode(7'b0000011, 3'b010);
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            #1;
            check("nto_req", {dmem_req, illegal}, 2'b10);
            next_cycle();
        end
        dmem_ready = 1'b1;
        next_cycle();
        dmem_ready = 1'b0;
        #1;
        check("nto_wb", {reg_we, wb_sel}, 3'b101);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
